// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds stores retired by the ROB head in a circular
// FIFO, drains them in order to data memory over a req/ack handshake, and
// offers a combinational byte-merging lookup so younger loads can forward
// committed-but-undrained store data.
module store_commit_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         commit_valid,
  input  logic [ADDR_W-1:0]            commit_addr,
  input  logic [DATA_W-1:0]            commit_data,
  input  logic [DATA_W/8-1:0]          commit_be,
  output logic                         commit_ready,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_be,
  input  logic                         mem_ack,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic [DATA_W/8-1:0]          ld_be,
  output logic [DATA_W-1:0]            ld_data,
  output logic                         ld_hit,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OFF_W = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF_W;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WA_W-1:0]  r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [BE_W-1:0]  r_be   [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] w_idx;
  logic             w_unused;

  // The byte-offset bits of both addresses are irrelevant: entries and
  // lookups work on whole words.
  assign w_unused = ^{commit_addr[OFF_W-1:0], ld_addr[OFF_W-1:0]};

  // No pass-through when full: readiness looks only at the registered count,
  // so a pop in the same cycle cannot make room for a push.
  assign commit_ready = (r_count != CNT_W'(DEPTH));
  assign w_push       = commit_valid && commit_ready;
  assign w_pop        = (r_state == REQ) && mem_ack;

  assign count = r_count;
  assign empty = (r_count == '0);

  // Occupancy after this cycle's push and pop; a coincident pair cancels.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, occupancy, entry validity and the drain FSM; reset abandons
  // any in-flight request so a late ack finds the FSM idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_state <= IDLE;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= w_count_next;
      case (r_state)
        IDLE: if (r_count != '0) r_state <= REQ;
        REQ:  if (w_pop && (w_count_next == '0)) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Entry payload is written only on an accepted commit; validity bits alone
  // decide whether an entry takes part in draining or forwarding.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= commit_addr[ADDR_W-1:OFF_W];
      r_data[r_tail] <= commit_data;
      r_be[r_tail]   <= commit_be;
    end
  end

  // The head entry is presented only while requesting, and zero otherwise.
  assign mem_req   = (r_state == REQ);
  assign mem_addr  = mem_req ? {r_addr[r_head], {OFF_W{1'b0}}} : '0;
  assign mem_wdata = mem_req ? r_data[r_head] : '0;
  assign mem_be    = mem_req ? r_be[r_head]   : '0;

  // Walk entries oldest to youngest from the head so that the youngest
  // matching store overwrites each byte last.
  always_comb begin
    ld_be   = '0;
    ld_data = '0;
    w_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_valid[w_idx] && (r_addr[w_idx] == ld_addr[ADDR_W-1:OFF_W])) begin
        ld_be = ld_be | r_be[w_idx];
        for (int b = 0; b < BE_W; b++) begin
          if (r_be[w_idx][b]) begin
            ld_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign ld_hit = &ld_be;

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Sits directly downstream of the reorder buffer's commit point, between the core and data memory.
- Captures stores as the ROB head retires them and holds them in a FIFO.
- Drains them in order to data memory over a req/ack handshake.
- Offers a combinational byte-merging lookup so the EX memory unit can forward committed-but-undrained store data to younger loads.

Parameters:
- DEPTH, 8, number of buffered stores; power of two, ≥2.
- ADDR_W, 32, byte address width.
- DATA_W, 32, store data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- commit_valid  in  1  ROB head is a store retiring this cycle.
- commit_addr  in  ADDR_W  store byte address; word-aligned part used.
- commit_data  in  DATA_W  store data, lane-aligned.
- commit_be  in  DATA_W/8  byte enables.
- commit_ready  out  1  buffer can accept a commit this cycle.
- mem_req  out  1  drain request to data memory.
- mem_addr  out  ADDR_W  head entry address, word-aligned.
- mem_wdata  out  DATA_W  head entry data.
- mem_be  out  DATA_W/8  head entry byte enables.
- mem_ack  in  1  memory accepted the current request.
- ld_addr  in  ADDR_W  load lookup address from EX.
- ld_be  out  DATA_W/8  bytes of ld_addr's word covered by buffered stores.
- ld_data  out  DATA_W  merged forwarded bytes; bytes not covered are 0.
- ld_hit  out  1  ld_be is all ones; the load may use ld_data.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage is a circular FIFO with head/tail pointers modulo DEPTH plus a registered count.
- Reset, asynchronous and taking effect immediately, including mid-drain:
  - count=0, pointers=0, state=IDLE, all entries invalid.
  - Outputs: mem_req=0, mem_addr/mem_wdata/mem_be=0, commit_ready=1, empty=1, ld_be=0, ld_hit=0, ld_data=0.
  - An in-flight request is abandoned; a subsequent mem_ack is ignored.
- Push:
  - commit_ready = (count != DEPTH), combinational from registered count.
  - No pass-through when full: a same-cycle pop does not raise commit_ready.
  - commit_valid && commit_ready writes the entry at tail; tail advances.
  - commit_valid while !commit_ready is a protocol violation; the entry is not written and state is unchanged. The ROB must hold the commit.
- Drain FSM, states IDLE and REQ:
  - IDLE: mem_req=0 and mem_* outputs = 0. Go to REQ on the next edge when count != 0.
  - REQ: mem_req=1; mem_addr/wdata/be show the head entry and stay stable until mem_ack.
  - mem_ack in REQ pops the head; head advances. If count after pop and push > 0, stay in REQ with the new head presented next cycle (back-to-back, no bubble); otherwise go to IDLE.
  - mem_ack while mem_req=0 is ignored.
- Latency: a commit accepted in cycle N has count≥1 in N+1; into an empty buffer, mem_req rises in N+2.
- Simultaneous push and pop: count unchanged; both pointers advance. Wrap-around is transparent.
- Forwarding is purely combinational from registered state:
  - Compare ld_addr[ADDR_W-1:2] against every valid entry, including the head currently being drained until its ack edge.
  - Bytes are merged per byte oldest→youngest, so the youngest store wins each byte.
  - ld_be = OR of matching entries' be.
  - A commit being written in the same cycle is not visible until the next cycle.
  - A load with partial coverage (ld_be nonzero, not all ones) must stall in EX until the entry drains. The buffer only reports coverage.
- count width arithmetic: full at count==DEPTH; never exceeds DEPTH or underflows.

Test Plan:
- Reset, then single commit: addr=0x100, data=0xDEADBEEF, be=0xF at cycle 1 → count=1 at cycle 2; mem_req=1, mem_addr=0x100 at cycle 3. mem_ack at cycle 5 → empty=1, mem_req=0 at cycle 6.
- Fill 8 commits with mem_ack held low → commit_ready=0 at count=8. A 9th commit_valid is dropped. Then ack 8 times consecutively → addresses emerge in commit order, with no bubble between requests.
- Forwarding merge: commit 0x200 data=0x11223344 be=0xF, then 0x202 data=0xAABB0000 be=0xC; lookup ld_addr=0x200 → ld_data=0xAABB3344, ld_be=0xF, ld_hit=1. A lookup of 0x204 → ld_be=0, ld_hit=0.
- Partial coverage: a single commit with be=0x3 at 0x300, lookup 0x300 → ld_be=0x3, ld_hit=0. After that entry is acked → ld_be=0.
- Wrap plus simultaneous push/pop: run 20 stores with commit and ack coinciding each cycle → count remains stable and data order is preserved across the pointer wrap.
- Async reset asserted mid-REQ with 3 entries → mem_req=0 and count=0 immediately, without waiting for a clock edge. A stray mem_ack after reset release → no state change.
